ram_stream_writer: RTL and testbench

- Write-side counterpart of the 8-bit single-port ROM/RAM read path; the writer is the side that fills memory.
- Accepts a valid/ready byte stream and writes it into consecutive addresses of a synchronous single-port RAM (altsyncram-style: address/data/wren, registered address).
- Used to load lookup tables at run time, so readers can later sweep the same address space.

---
 rtl/ram_stream_writer.sv | 179 +++++++++++++++++
 tb/tb_ram_stream_writer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_writer.sv
// Writes a valid/ready byte stream into consecutive addresses of a synchronous single-port RAM.
// Optional read-back checksum verification is enabled with `define VERIFY_EN.
module ram_stream_writer #(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  input  logic [DATA_W-1:0] q,
  output logic              busy,
  output logic              done,
  output logic              verify_ok
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WRITE  = 2'd1,
`ifdef VERIFY_EN
    S_VERIFY = 2'd3,
`endif
    S_DONE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_rem;
  logic [DATA_W-1:0]   r_wr_sum;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_wren;
  logic                r_done;
  logic                r_vok;
  logic                w_beat;
  logic                w_last_beat;
  logic                w_ready;

  assign w_ready     = (r_state == S_WRITE) && (r_rem != '0);
  assign w_beat      = in_valid && w_ready;
  assign w_last_beat = w_beat && (r_rem == (ADDR_W+1)'(1));

`ifdef VERIFY_EN
  logic [ADDR_W-1:0]     r_vptr;
  logic [ADDR_W:0]       r_vcnt;
  logic [DATA_W-1:0]     r_rd_sum;
  logic [READ_LATENCY:0] r_vpipe;
  logic                  w_issue;
  logic                  w_last_sample;

  // r_vpipe[k] marks that the address shown k cycles ago is awaiting its q.
  assign w_issue       = (r_state == S_VERIFY) && (r_vcnt != '0);
  assign w_last_sample = (r_state == S_VERIFY) && (r_vcnt == '0) &&
                         (r_vpipe[READ_LATENCY-1:0] == '0) && r_vpipe[READ_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vpipe <= '0;
    end else begin
      r_vpipe <= {r_vpipe[READ_LATENCY-1:0], w_issue};
    end
  end
`else
  logic w_unused_q;
  assign w_unused_q = ^q;
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (length == '0) ? S_DONE : S_WRITE;
        end
      end
      S_WRITE: begin
        if (w_last_beat) begin
`ifdef VERIFY_EN
          w_next = S_VERIFY;
`else
          w_next = S_DONE;
`endif
        end
      end
`ifdef VERIFY_EN
      S_VERIFY: begin
        if (w_last_sample) begin
          w_next = S_DONE;
        end
      end
`endif
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ptr    <= '0;
      r_rem    <= '0;
      r_wr_sum <= '0;
      r_addr   <= '0;
      r_data   <= '0;
      r_wren   <= 1'b0;
      r_done   <= 1'b0;
      r_vok    <= 1'b1;
`ifdef VERIFY_EN
      r_vptr   <= '0;
      r_vcnt   <= '0;
      r_rd_sum <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == S_DONE);
      r_wren  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ptr    <= base_addr;
            r_rem    <= length;
            r_wr_sum <= '0;
            r_vok    <= 1'b1;
`ifdef VERIFY_EN
            r_vptr   <= base_addr;
            r_vcnt   <= length;
            r_rd_sum <= '0;
`endif
          end
        end
        S_WRITE: begin
          if (w_beat) begin
            r_addr   <= r_ptr;
            r_data   <= in_data;
            r_wren   <= 1'b1;
            r_ptr    <= r_ptr + ADDR_W'(1);
            r_rem    <= r_rem - (ADDR_W+1)'(1);
            r_wr_sum <= r_wr_sum + in_data;
          end
        end
`ifdef VERIFY_EN
        S_VERIFY: begin
          if (w_issue) begin
            r_addr <= r_vptr;
            r_vptr <= r_vptr + ADDR_W'(1);
            r_vcnt <= r_vcnt - (ADDR_W+1)'(1);
          end
          if (r_vpipe[READ_LATENCY]) begin
            r_rd_sum <= r_rd_sum + q;
          end
          // The final q is folded in directly so the verdict lands with the DONE transition.
          if (w_last_sample) begin
            r_vok <= ((r_rd_sum + q) == r_wr_sum);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign in_ready  = w_ready;
  assign address   = r_addr;
  assign data      = r_data;
  assign wren      = r_wren;
  assign done      = r_done;
  assign busy      = (r_state != S_IDLE) || r_done;
  assign verify_ok = r_vok;

endmodule

// File: tb/tb_ram_stream_writer.sv
// Directed bench for ram_stream_writer with a latency-2 RAM model; honours VERIFY_EN.
module tb_ram_stream_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] length;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] address;
  logic [7:0] data;
  logic       wren;
  logic [7:0] q;
  logic       busy;
  logic       done;
  logic       verify_ok;

  int checks   = 0;
  int failures = 0;

  logic [7:0] wa_q[$];
  logic [7:0] wd_q[$];
  logic [7:0] mem[256];
  logic [7:0] ra;
  logic       corrupt_en = 1'b0;

  ram_stream_writer #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .address(address),
    .data(data), .wren(wren), .q(q), .busy(busy), .done(done), .verify_ok(verify_ok)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (wren) begin
      wa_q.push_back(address);
      wd_q.push_back(data);
      mem[address] <= data;
    end
    ra <= address;
    q  <= mem[ra];
    if (corrupt_en && wa_q.size() == 8 && !wren) mem[8'h57] <= 8'hEE;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Cycle 0 carries start; exp_done is the cycle index in which done is visible.
  task automatic run_load(input string tag, input logic [7:0] base, input int len,
                          input logic [7:0] mul, input logic [31:0] vpat, input int plen,
                          input int exp_done_in, input logic exp_vok);
    int   cyc, beats, done_at, exp_done;
    bit   rdy_chk;
    logic vok_at_done;
    exp_done = exp_done_in;
`ifdef VERIFY_EN
    if (len > 0) exp_done += len + 3;
`endif
    wa_q.delete();
    wd_q.delete();
    base_addr = base;
    length    = 9'(len);
    start     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 'x;
    step;
    start   = 1'b0;
    cyc     = 1;
    beats   = 0;
    done_at = -1;
    rdy_chk = 0;
    vok_at_done = 1'bx;
    while (cyc <= exp_done + 20 && done_at < 0) begin
      if (done === 1'b1) begin
        done_at     = cyc;
        vok_at_done = verify_ok;
      end else begin
        if (beats == len && !rdy_chk) begin
          rdy_chk = 1;
          check({tag, "_ready_after_last"}, 32'(in_ready), 32'd0);
        end
        in_valid = (cyc - 1 < plen) ? vpat[cyc-1] : (beats < len);
        in_data  = in_valid ? 8'(mul * (beats + 1)) : 'x;
        if (in_valid && in_ready) beats++;
        step;
        cyc++;
      end
    end
    in_valid = 1'b0;
    in_data  = 'x;
    check({tag, "_done_cycle"}, 32'(done_at), 32'(exp_done));
    check({tag, "_verify_ok"}, 32'(vok_at_done), 32'(exp_vok));
    step;
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_nwrites"}, 32'(wa_q.size()), 32'(len));
    for (int k = 0; k < len && k < wa_q.size(); k++) begin
      check($sformatf("%s_addr%0d", tag, k), 32'(wa_q[k]), 32'(8'(base + k)));
      check($sformatf("%s_data%0d", tag, k), 32'(wd_q[k]), 32'(8'(mul * (k + 1))));
    end
  endtask

  initial begin
    int dn;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    in_valid  = 1'b0;
    in_data   = 'x;
    step;
    step;
    check("rst_address", 32'(address), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_verify_ok", 32'(verify_ok), 32'd1);
    rst_n = 1'b1;
    step;

    run_load("basic", 8'h00, 4, 8'h11, 32'h0, 0, 6, 1'b1);
    run_load("gaps", 8'h10, 3, 8'h07, 32'h29, 6, 8, 1'b1);
    run_load("wrap", 8'hFE, 4, 8'h03, 32'h0, 0, 6, 1'b1);
    run_load("len0", 8'h33, 0, 8'h01, 32'h0, 0, 2, 1'b1);
    run_load("len256", 8'h00, 256, 8'h01, 32'h0, 0, 258, 1'b1);

    // Reset after two of eight beats.
    wa_q.delete();
    wd_q.delete();
    base_addr = 8'h20;
    length    = 9'd8;
    start     = 1'b1;
    step;
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'hA1;
    step;
    in_data = 8'hA2;
    step;
    check("abort_wren_before", 32'(wren), 32'd1);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 'x;
    step;
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    step;
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_data  = 8'hC3;
      step;
      if (done === 1'b1) dn++;
    end
    in_valid = 1'b0;
    in_data  = 'x;
    check("abort_no_done", 32'(dn), 32'd0);
    check("abort_nwrites", 32'(wa_q.size()), 32'd2);
    run_load("after_rst", 8'h40, 1, 8'h5A, 32'h0, 0, 3, 1'b1);

    run_load("verify_good", 8'h50, 8, 8'h01, 32'h0, 0, 10, 1'b1);
`ifdef VERIFY_EN
    corrupt_en = 1'b1;
    run_load("verify_bad", 8'h50, 8, 8'h01, 32'h0, 0, 10, 1'b0);
    corrupt_en = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
